// File: rtl/adc_serial_ctrl.sv
// Serial ADC frame controller: turns a conversion-start edge into one CS/SCLK frame
// and presents the captured offset-binary sample in parallel with a one-cycle valid pulse.
module adc_serial_ctrl #(
  parameter int DATA_WIDTH = 11,
  parameter int FRAME_BITS = 16,
  parameter int LEAD_BITS  = 4,
  parameter int SCLK_DIV   = 2,
  parameter int QUIET_CYC  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_convst,
  input  logic                  i_clr_ovr,
  output logic                  o_adc_cs_n,
  output logic                  o_adc_sclk,
  input  logic                  i_adc_sdo,
  output logic [DATA_WIDTH-1:0] o_adc_data,
  output logic                  o_adc_busy,
  output logic                  o_adc_rd_valid,
  output logic                  o_overrun
);

  localparam int HW = $clog2(SCLK_DIV + 1);
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int QW = $clog2(QUIET_CYC + 1);
  // Leading bits fall off the top of the shift register before the frame ends and
  // never reach the output, so only the sample and trailing bits are retained.
  localparam int KW = FRAME_BITS - LEAD_BITS;

  localparam logic [HW-1:0] HALF_LOAD  = HW'(SCLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LOAD   = BW'(FRAME_BITS);
  localparam logic [QW-1:0] QUIET_LOAD = QW'(QUIET_CYC - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CS_SETUP = 2'd1,
    SHIFT    = 2'd2,
    QUIET    = 2'd3
  } state_t;

  state_t          state_r;
  logic [HW-1:0]   half_cnt_r;
  logic [BW-1:0]   bit_cnt_r;
  logic [QW-1:0]   quiet_cnt_r;
  logic [KW-1:0]   shreg_r;
  logic            convst_q_r;
  logic            start_s;
  logic            drop_busy_s;

  assign start_s     = i_convst & ~convst_q_r;
  assign drop_busy_s = start_s & (state_r != IDLE);

  // Frame sequencer: all serial-interface outputs and status flags come straight from flops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r        <= IDLE;
      half_cnt_r     <= {HW{1'b0}};
      bit_cnt_r      <= {BW{1'b0}};
      quiet_cnt_r    <= {QW{1'b0}};
      shreg_r        <= {KW{1'b0}};
      convst_q_r     <= 1'b1;
      o_adc_cs_n     <= 1'b1;
      o_adc_sclk     <= 1'b1;
      o_adc_data     <= {DATA_WIDTH{1'b0}};
      o_adc_busy     <= 1'b0;
      o_adc_rd_valid <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      convst_q_r     <= i_convst;
      o_adc_rd_valid <= 1'b0;

      // A drop in the same cycle as a clear must still be reported.
      if (drop_busy_s) begin
        o_overrun <= 1'b1;
      end else if (i_clr_ovr) begin
        o_overrun <= 1'b0;
      end else begin
        o_overrun <= o_overrun;
      end

      case (state_r)
        IDLE: begin
          if (start_s && i_en) begin
            state_r    <= CS_SETUP;
            o_adc_cs_n <= 1'b0;
            o_adc_busy <= 1'b1;
            o_adc_sclk <= 1'b1;
            half_cnt_r <= HALF_LOAD;
          end else begin
            state_r <= IDLE;
          end
        end

        CS_SETUP: begin
          if (half_cnt_r != {HW{1'b0}}) begin
            half_cnt_r <= half_cnt_r - HW'(1);
          end else begin
            state_r    <= SHIFT;
            o_adc_sclk <= 1'b0;
            half_cnt_r <= HALF_LOAD;
            bit_cnt_r  <= BIT_LOAD;
          end
        end

        SHIFT: begin
          if (half_cnt_r != {HW{1'b0}}) begin
            half_cnt_r <= half_cnt_r - HW'(1);
          end else if (!o_adc_sclk) begin
            // Last low cycle: the ADC has had the whole low phase to settle SDO.
            shreg_r    <= {shreg_r[KW-2:0], i_adc_sdo};
            o_adc_sclk <= 1'b1;
            half_cnt_r <= HALF_LOAD;
          end else if (bit_cnt_r != BW'(1)) begin
            bit_cnt_r  <= bit_cnt_r - BW'(1);
            o_adc_sclk <= 1'b0;
            half_cnt_r <= HALF_LOAD;
          end else begin
            state_r        <= QUIET;
            o_adc_cs_n     <= 1'b1;
            o_adc_sclk     <= 1'b1;
            bit_cnt_r      <= {BW{1'b0}};
            quiet_cnt_r    <= QUIET_LOAD;
            o_adc_rd_valid <= 1'b1;
            o_adc_data     <= shreg_r[KW-1 -: DATA_WIDTH];
          end
        end

        QUIET: begin
          if (quiet_cnt_r != {QW{1'b0}}) begin
            quiet_cnt_r <= quiet_cnt_r - QW'(1);
          end else begin
            state_r    <= IDLE;
            o_adc_busy <= 1'b0;
          end
        end

        default: begin
          state_r    <= IDLE;
          o_adc_cs_n <= 1'b1;
          o_adc_sclk <= 1'b1;
          o_adc_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_serial_ctrl.sv
// Bench for adc_serial_ctrl: behavioural ADC shifting a random frame out on SCLK falls,
// expectations from frame arithmetic and closed-form timing.
module tb_adc_serial_ctrl;
  localparam int DW   = 11;
  localparam int FB   = 16;
  localparam int LB   = 4;
  localparam int SD   = 2;
  localparam int QC   = 4;
  localparam int FB_B = 12;
  localparam int MAXK = 200;
  localparam int NONE = -100;
  localparam int RV_K   = 1 + SD * (2 * FB + 1);
  localparam int BUSY_K = RV_K + QC;
  localparam int RV_KB   = 1 + 1 * (2 * FB_B + 1);
  localparam int BUSY_KB = RV_KB + 1;

  logic clk = 1'b0;
  logic rst, en, convst, clr_ovr, adc_sdo;
  logic adc_cs_n, adc_sclk, adc_busy, adc_rd_valid, overrun;
  logic [DW-1:0] adc_data;
  logic convst_b, sdo_b, cs_n_b, sclk_b, busy_b, rv_b, ovr_b;
  logic [DW-1:0] data_b;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_data;
  logic [FB-1:0] frame_a;
  logic [FB_B-1:0] frame_b;

  logic s_cs [0:MAXK];
  logic s_sclk [0:MAXK];
  logic s_busy [0:MAXK];
  logic s_rv [0:MAXK];
  logic s_ovr [0:MAXK];
  logic [DW-1:0] s_data [0:MAXK];
  int m_ncsf, m_nrv, m_nrise, m_nlow, m_busy_fall, m_ovr_k, m_busy_seen;
  int m_csf [0:3];
  int m_rvk [0:3];
  logic [DW-1:0] m_rvd [0:3];

  always #5 clk = ~clk;

  adc_serial_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_convst(convst), .i_clr_ovr(clr_ovr),
    .o_adc_cs_n(adc_cs_n), .o_adc_sclk(adc_sclk), .i_adc_sdo(adc_sdo),
    .o_adc_data(adc_data), .o_adc_busy(adc_busy), .o_adc_rd_valid(adc_rd_valid),
    .o_overrun(overrun)
  );

  adc_serial_ctrl #(.DATA_WIDTH(DW), .FRAME_BITS(FB_B), .LEAD_BITS(0), .SCLK_DIV(1), .QUIET_CYC(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_en(1'b1), .i_convst(convst_b), .i_clr_ovr(1'b0),
    .o_adc_cs_n(cs_n_b), .o_adc_sclk(sclk_b), .i_adc_sdo(sdo_b),
    .o_adc_data(data_b), .o_adc_busy(busy_b), .o_adc_rd_valid(rv_b),
    .o_overrun(ovr_b)
  );

  // ADC model: presents the next frame bit, MSB first, after each SCLK fall while selected.
  int idx_a;
  logic prev_a;
  always @(negedge clk) begin
    if (adc_cs_n !== 1'b0) begin
      idx_a = 0; prev_a = 1'b1; adc_sdo = 1'b0;
    end else begin
      if (prev_a && !adc_sclk) begin
        if (idx_a < FB) adc_sdo = frame_a[FB-1-idx_a];
        idx_a++;
      end
      prev_a = adc_sclk;
    end
  end

  int idx_b;
  logic prev_b;
  always @(negedge clk) begin
    if (cs_n_b !== 1'b0) begin
      idx_b = 0; prev_b = 1'b1; sdo_b = 1'b0;
    end else begin
      if (prev_b && !sclk_b) begin
        if (idx_b < FB_B) sdo_b = frame_b[FB_B-1-idx_b];
        idx_b++;
      end
      prev_b = sclk_b;
    end
  end

  function automatic logic [DW-1:0] exp_word(input logic [FB-1:0] f);
    return DW'(f >> (FB - LB - DW));
  endfunction

  task automatic summarize(input int ncyc);
    logic pcs, psclk, pbusy;
    m_ncsf = 0; m_nrv = 0; m_nrise = 0; m_nlow = 0;
    m_busy_fall = NONE; m_ovr_k = NONE; m_busy_seen = 0;
    for (int i = 0; i < 4; i++) begin m_csf[i] = NONE; m_rvk[i] = NONE; m_rvd[i] = '0; end
    pcs = 1'b1; psclk = 1'b1; pbusy = 1'b0;
    for (int k = 0; k <= ncyc; k++) begin
      if (pcs === 1'b1 && s_cs[k] === 1'b0) begin
        if (m_ncsf < 4) m_csf[m_ncsf] = k;
        m_ncsf++;
      end
      if (s_cs[k] === 1'b0 && s_sclk[k] === 1'b0) m_nlow++;
      if (psclk === 1'b0 && s_sclk[k] === 1'b1) m_nrise++;
      if (s_rv[k] === 1'b1) begin
        if (m_nrv < 4) begin m_rvk[m_nrv] = k; m_rvd[m_nrv] = s_data[k]; end
        m_nrv++;
      end
      if (s_busy[k] === 1'b1) m_busy_seen = 1;
      if (pbusy === 1'b1 && s_busy[k] === 1'b0 && m_busy_fall == NONE) m_busy_fall = k;
      if (s_ovr[k] === 1'b1 && m_ovr_k == NONE) m_ovr_k = k;
      pcs = s_cs[k]; psclk = s_sclk[k]; pbusy = s_busy[k];
    end
  endtask

  // Raises convst in cycle 0 and records ncyc+1 cycles; optional events at given cycles.
  task automatic run_a(input logic [FB-1:0] f1, input logic [FB-1:0] f2, input int ncyc,
                       input int edge2_k, input int en_off_k, input int rst_k, input int clr_k);
    @(posedge clk); #1;
    frame_a = f1;
    convst = 1'b1;
    for (int k = 0; k <= ncyc; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        if (k == 2) convst = 1'b0;
        if (k == edge2_k) begin convst = 1'b1; frame_a = f2; end
        if (k == edge2_k + 2) convst = 1'b0;
        if (k == en_off_k) en = 1'b0;
        clr_ovr = (k == clr_k) ? 1'b1 : 1'b0;
        if (k == rst_k) begin rst = 1'b1; convst = 1'b1; end
        if (k == rst_k + 2) rst = 1'b0;
      end
      @(negedge clk);
      s_cs[k] = adc_cs_n; s_sclk[k] = adc_sclk; s_busy[k] = adc_busy;
      s_rv[k] = adc_rd_valid; s_ovr[k] = overrun; s_data[k] = adc_data;
    end
    summarize(ncyc);
  endtask

  task automatic clear_overrun();
    @(posedge clk); #1 clr_ovr = 1'b1;
    @(posedge clk); #1 clr_ovr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; convst = 1'b0; clr_ovr = 1'b0; convst_b = 1'b0;
    frame_a = '0; frame_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (adc_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", adc_cs_n); end
    checks++; if (adc_sclk !== 1'b1) begin errors++; $display("FAIL reset_sclk: got %b expected 1", adc_sclk); end
    checks++; if (adc_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", adc_busy); end
    checks++; if (adc_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", adc_rd_valid); end
    checks++; if (adc_data !== 11'h000) begin errors++; $display("FAIL reset_data: got %h expected 000", adc_data); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (cs_n_b !== 1'b1) begin errors++; $display("FAIL reset_cs_n_b: got %b expected 1", cs_n_b); end
    exp_data = '0;
  endtask

  task automatic test_single_frame();
    logic [FB-1:0] f;
    for (int i = 0; i < 4; i++) begin
      f = (i == 0) ? 16'h0ABC : FB'($urandom);
      run_a(f, f, 80, NONE, NONE, NONE, NONE);
      checks++; if (m_ncsf !== 1) begin errors++; $display("FAIL single_cs_falls: got %0d expected 1", m_ncsf); end
      checks++; if (m_csf[0] !== 1) begin errors++; $display("FAIL single_cs_fall_cycle: got %0d expected 1", m_csf[0]); end
      checks++; if (s_sclk[SD] !== 1'b1 || s_sclk[SD+1] !== 1'b0) begin errors++; $display("FAIL single_setup_sclk: got %b%b expected 10", s_sclk[SD], s_sclk[SD+1]); end
      checks++; if (m_nrise !== FB) begin errors++; $display("FAIL single_sclk_pulses: got %0d expected %0d", m_nrise, FB); end
      checks++; if (m_nlow !== FB * SD) begin errors++; $display("FAIL single_sclk_low_cycles: got %0d expected %0d", m_nlow, FB * SD); end
      checks++; if (m_nrv !== 1) begin errors++; $display("FAIL single_rv_count: got %0d expected 1", m_nrv); end
      checks++; if (m_rvk[0] !== RV_K) begin errors++; $display("FAIL single_rv_cycle: got %0d expected %0d", m_rvk[0], RV_K); end
      checks++; if (m_rvd[0] !== exp_word(f)) begin errors++; $display("FAIL single_data: got %h expected %h", m_rvd[0], exp_word(f)); end
      checks++; if (s_data[RV_K-1] !== exp_data) begin errors++; $display("FAIL single_data_hold_before: got %h expected %h", s_data[RV_K-1], exp_data); end
      checks++; if (s_data[80] !== exp_word(f)) begin errors++; $display("FAIL single_data_hold_after: got %h expected %h", s_data[80], exp_word(f)); end
      checks++; if (m_busy_fall !== BUSY_K) begin errors++; $display("FAIL single_busy_fall: got %0d expected %0d", m_busy_fall, BUSY_K); end
      checks++; if (m_ovr_k !== NONE) begin errors++; $display("FAIL single_overrun: got cycle %0d expected none", m_ovr_k); end
      exp_data = exp_word(f);
    end
  endtask

  task automatic test_back_to_back();
    run_a(16'hFFFF, 16'h0000, 160, BUSY_K, NONE, NONE, NONE);
    checks++; if (m_ncsf !== 2) begin errors++; $display("FAIL b2b_cs_falls: got %0d expected 2", m_ncsf); end
    checks++; if (m_csf[1] !== BUSY_K + 1) begin errors++; $display("FAIL b2b_second_cs_fall: got %0d expected %0d", m_csf[1], BUSY_K + 1); end
    checks++; if (m_nrv !== 2) begin errors++; $display("FAIL b2b_rv_count: got %0d expected 2", m_nrv); end
    checks++; if (m_rvd[0] !== exp_word(16'hFFFF)) begin errors++; $display("FAIL b2b_data0: got %h expected %h", m_rvd[0], exp_word(16'hFFFF)); end
    checks++; if (m_rvk[1] !== BUSY_K + RV_K) begin errors++; $display("FAIL b2b_rv1_cycle: got %0d expected %0d", m_rvk[1], BUSY_K + RV_K); end
    checks++; if (m_rvd[1] !== exp_word(16'h0000)) begin errors++; $display("FAIL b2b_data1: got %h expected %h", m_rvd[1], exp_word(16'h0000)); end
    checks++; if (m_ovr_k !== NONE) begin errors++; $display("FAIL b2b_overrun: got cycle %0d expected none", m_ovr_k); end
    exp_data = exp_word(16'h0000);
  endtask

  task automatic test_overrun();
    logic [FB-1:0] f;
    f = FB'($urandom);
    run_a(f, f, 80, 30, NONE, NONE, NONE);
    checks++; if (m_nrv !== 1 || m_rvk[0] !== RV_K) begin errors++; $display("FAIL ovr_frame_rv: got %0d pulses at %0d expected 1 at %0d", m_nrv, m_rvk[0], RV_K); end
    checks++; if (m_rvd[0] !== exp_word(f)) begin errors++; $display("FAIL ovr_frame_data: got %h expected %h", m_rvd[0], exp_word(f)); end
    checks++; if (m_ncsf !== 1) begin errors++; $display("FAIL ovr_cs_falls: got %0d expected 1", m_ncsf); end
    checks++; if (m_ovr_k !== 31) begin errors++; $display("FAIL ovr_set_cycle: got %0d expected 31", m_ovr_k); end
    checks++; if (s_ovr[80] !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", s_ovr[80]); end
    exp_data = exp_word(f);
    clear_overrun();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
    f = FB'($urandom);
    run_a(f, f, 80, 30, NONE, NONE, 30);
    checks++; if (s_ovr[30] !== 1'b0 || s_ovr[31] !== 1'b1) begin errors++; $display("FAIL ovr_set_beats_clear: got %b%b expected 01", s_ovr[30], s_ovr[31]); end
    exp_data = exp_word(f);
    clear_overrun();
    f = FB'($urandom);
    run_a(f, f, 90, BUSY_K - 1, NONE, NONE, NONE);
    checks++; if (m_ncsf !== 1) begin errors++; $display("FAIL ovr_last_quiet_cs: got %0d expected 1", m_ncsf); end
    checks++; if (m_ovr_k !== BUSY_K) begin errors++; $display("FAIL ovr_last_quiet_set: got %0d expected %0d", m_ovr_k, BUSY_K); end
    exp_data = exp_word(f);
    clear_overrun();
  endtask

  task automatic test_enable();
    logic [FB-1:0] f;
    en = 1'b0;
    f = FB'($urandom);
    run_a(f, f, 80, NONE, NONE, NONE, NONE);
    checks++; if (m_ncsf !== 0 || m_busy_seen !== 0) begin errors++; $display("FAIL en_off_activity: got %0d cs falls busy %0d expected none", m_ncsf, m_busy_seen); end
    checks++; if (m_nrv !== 0) begin errors++; $display("FAIL en_off_rv: got %0d expected 0", m_nrv); end
    checks++; if (m_ovr_k !== NONE) begin errors++; $display("FAIL en_off_overrun: got cycle %0d expected none", m_ovr_k); end
    checks++; if (s_data[80] !== exp_data) begin errors++; $display("FAIL en_off_data_hold: got %h expected %h", s_data[80], exp_data); end
    en = 1'b1;
    f = 16'h1234;
    run_a(f, f, 80, NONE, 20, NONE, NONE);
    checks++; if (m_nrv !== 1 || m_rvk[0] !== RV_K) begin errors++; $display("FAIL en_drop_rv: got %0d pulses at %0d expected 1 at %0d", m_nrv, m_rvk[0], RV_K); end
    checks++; if (m_rvd[0] !== exp_word(f)) begin errors++; $display("FAIL en_drop_data: got %h expected %h", m_rvd[0], exp_word(f)); end
    checks++; if (m_busy_fall !== BUSY_K) begin errors++; $display("FAIL en_drop_busy_fall: got %0d expected %0d", m_busy_fall, BUSY_K); end
    exp_data = exp_word(f);
    en = 1'b1;
  endtask

  task automatic test_reset_midframe();
    logic [FB-1:0] f;
    f = FB'($urandom);
    run_a(f, f, 70, NONE, NONE, 40, NONE);
    checks++; if (s_cs[40] !== 1'b0) begin errors++; $display("FAIL rstmid_active: got cs %b expected 0", s_cs[40]); end
    checks++; if (s_cs[41] !== 1'b1 || s_sclk[41] !== 1'b1) begin errors++; $display("FAIL rstmid_pins: got cs %b sclk %b expected 1 1", s_cs[41], s_sclk[41]); end
    checks++; if (s_busy[41] !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", s_busy[41]); end
    checks++; if (s_data[41] !== 11'h000) begin errors++; $display("FAIL rstmid_data: got %h expected 000", s_data[41]); end
    checks++; if (m_nrv !== 0) begin errors++; $display("FAIL rstmid_rv: got %0d expected 0", m_nrv); end
    checks++; if (m_ncsf !== 1) begin errors++; $display("FAIL rstmid_high_convst_no_frame: got %0d cs falls expected 1", m_ncsf); end
    exp_data = '0;
    @(posedge clk); #1 convst = 1'b0;
    f = FB'($urandom);
    run_a(f, f, 80, NONE, NONE, NONE, NONE);
    checks++; if (m_nrv !== 1 || m_rvk[0] !== RV_K) begin errors++; $display("FAIL rstmid_rearm_rv: got %0d pulses at %0d expected 1 at %0d", m_nrv, m_rvk[0], RV_K); end
    checks++; if (m_rvd[0] !== exp_word(f)) begin errors++; $display("FAIL rstmid_rearm_data: got %h expected %h", m_rvd[0], exp_word(f)); end
    exp_data = exp_word(f);
  endtask

  task automatic test_param_sweep();
    logic [FB_B-1:0] f;
    logic [DW-1:0] rvd, want;
    logic pb;
    int first_cs, nrv, rvk, bf;
    for (int i = 0; i < 3; i++) begin
      f = FB_B'($urandom);
      want = DW'(f >> (FB_B - DW));
      frame_b = f;
      first_cs = NONE; nrv = 0; rvk = NONE; bf = NONE; rvd = '0; pb = 1'b0;
      @(posedge clk); #1 convst_b = 1'b1;
      for (int k = 0; k <= 40; k++) begin
        if (k > 0) begin
          @(posedge clk); #1;
          if (k == 2) convst_b = 1'b0;
        end
        @(negedge clk);
        if (cs_n_b === 1'b0 && first_cs == NONE) first_cs = k;
        if (rv_b === 1'b1) begin nrv++; rvk = k; rvd = data_b; end
        if (pb === 1'b1 && busy_b === 1'b0 && bf == NONE) bf = k;
        pb = busy_b;
      end
      checks++; if (first_cs !== 1) begin errors++; $display("FAIL sweep_cs_fall: got %0d expected 1", first_cs); end
      checks++; if (nrv !== 1 || rvk !== RV_KB) begin errors++; $display("FAIL sweep_rv: got %0d pulses at %0d expected 1 at %0d", nrv, rvk, RV_KB); end
      checks++; if (rvd !== want) begin errors++; $display("FAIL sweep_data: got %h expected %h", rvd, want); end
      checks++; if (bf !== BUSY_KB) begin errors++; $display("FAIL sweep_busy_fall: got %0d expected %0d", bf, BUSY_KB); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overrun();
    test_enable();
    test_reset_midframe();
    test_param_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
